// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped peripherals on the MIPS data bus:
// register offsets, status bit positions and the UART serializer state type.
package mmio_pkg;

  localparam logic [31:0] UART_BASE  = 32'hFFFF_FF00;
  localparam logic [31:0] TXDATA_OFS = 32'h0000_0000;
  localparam logic [31:0] STATUS_OFS = 32'h0000_0004;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

endpackage

// File: rtl/uart_tx_mmio_if.sv
// Processor data-bus view seen by a memory-mapped peripheral: store strobe,
// byte address, store data and combinational read data.
interface uart_tx_mmio_if;
  logic        we;
  logic [31:0] a;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output we, output a, output wd, input rd);
  modport slave  (input we, input a, input wd, output rd);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full and pop while empty
// are ignored. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA stores feed a byte FIFO drained by
// a serializer; STATUS reports busy/empty/full and a sticky overflow flag.
module uart_tx_mmio
  import mmio_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = UART_BASE
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_mmio_if.slave  bus,
  output logic           tx,
  output logic           busy
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  logic          hit, wr_txdata, wr_status;
  logic          fifo_pop, fifo_full, fifo_empty;
  logic [7:0]    fifo_dout;
  logic [CW-1:0] fifo_count;
  logic          ovf_q, ovf_d;
  logic [31:0]   status;

  uart_state_e   state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          baud_end;

  assign hit       = (bus.a[31:3] == BASE_ADDR[31:3]);
  assign wr_txdata = bus.we && hit && (bus.a[2] == TXDATA_OFS[2]);
  assign wr_status = bus.we && hit && (bus.a[2] == STATUS_OFS[2]);

  // The FIFO drops the push itself when full, judged on the pre-edge count.
  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (wr_txdata),
    .pop_i   (fifo_pop),
    .din_i   (bus.wd[7:0]),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Set has priority over a same-cycle software clear.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_txdata && fifo_full)             ovf_d = 1'b1;
    else if (wr_status && bus.wd[ST_OVF])   ovf_d = 1'b0;
  end

  always_comb begin
    status           = '0;
    status[ST_BUSY]  = busy;
    status[ST_EMPTY] = fifo_empty;
    status[ST_FULL]  = fifo_full;
    status[ST_OVF]   = ovf_q;
  end

  assign bus.rd = (hit && (bus.a[2] == STATUS_OFS[2])) ? status : '0;

  assign baud_end = (baud_q == BAUD_LAST);

  // tx_d is the line level for the state being entered, so tx stays a pure flop output.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        tx_d   = 1'b1;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          state_d  = START;
          tx_d     = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_d    = '0;
          bit_idx_d = '0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            state_d  = START;
            tx_d     = 1'b0;
          end else begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: directed bus stores push expected bytes into a
// scoreboard; a line monitor decodes frames from tx and compares them.
module tb_uart_tx_mmio;

  localparam int          CPB  = 4;
  localparam int          FRM  = 10 * CPB;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;

  logic clk;
  logic reset;
  logic tx;
  logic busy;

  uart_tx_mmio_if bus ();

  uart_tx_mmio #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .BASE_ADDR    (BASE)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .busy  (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0] exp_q [$];
  int         starts [$];
  int         frames_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- line monitor / scoreboard consumer ----------------
  logic        in_frame = 1'b0;
  int          n_samp   = 0;
  logic [FRM-1:0] samp;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 1'b0;
      n_samp   = 0;
    end else if (!in_frame) begin
      if (tx === 1'b0) begin
        in_frame = 1'b1;
        starts.push_back(cyc);
        samp[0] = tx;
        n_samp  = 1;
      end
    end else begin
      samp[n_samp] = tx;
      n_samp++;
      if (n_samp == FRM) begin
        logic       shape_ok;
        logic [7:0] got;
        shape_ok = (samp[0] == 1'b0) && (samp[9*CPB] == 1'b1);
        for (int b = 0; b < 10; b++)
          for (int s = 1; s < CPB; s++)
            if (samp[b*CPB+s] !== samp[b*CPB]) shape_ok = 1'b0;
        for (int i = 0; i < 8; i++) got[i] = samp[(i+1)*CPB];
        check("frame_shape", {31'b0, shape_ok}, 32'd1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", {24'b0, got}, 32'hFFFF_FFFF);
        end else begin
          check("frame_byte", {24'b0, got}, {24'b0, exp_q.pop_front()});
        end
        frames_done++;
        in_frame = 1'b0;
        n_samp   = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  // Called at posedge+1; the store takes effect on the next rising edge.
  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit expect_sent);
    bus.we = 1'b1;
    bus.a  = addr;
    bus.wd = data;
    if (expect_sent) exp_q.push_back(data[7:0]);
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    bus.a = addr;
    #1;
    check(name, bus.rd, exp);
  endtask

  task automatic wait_frames(input string name, input int target, input int budget);
    int k = 0;
    while (frames_done < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(name, frames_done, target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wcyc;
    int k;

    reset  = 1'b1;
    bus.we = 1'b0;
    bus.a  = '0;
    bus.wd = '0;
    #22;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    rd_check("reset_status", BASE + 4, 32'h2);
    check("reset_tx", {31'b0, tx}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);

    // Single frame 0x55: line is idle one cycle after the push, then start bit
    base = frames_done;
    starts.delete();
    wr(BASE, 32'h55, 1);
    wcyc = cyc;
    check("tx_high_after_push", {31'b0, tx}, 32'd1);
    @(posedge clk);
    #1;
    check("tx_start_low", {31'b0, tx}, 32'd0);
    check("busy_rise", {31'b0, busy}, 32'd1);
    wait_frames("single_frame_done", base + 1, 2 * FRM);
    if (starts.size() > 0) check("start_latency", starts[0] - wcyc, 32'd1);
    else check("start_seen", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    check("single_busy_end", {31'b0, busy}, 32'd0);
    rd_check("single_status_end", BASE + 4, 32'h2);

    // Overflow: 0x01 popped at once, 0x02..0x05 fill, 0x06 dropped
    base = frames_done;
    starts.delete();
    for (int i = 1; i <= 6; i++) wr(BASE, i, i <= 5);
    rd_check("ovf_status", BASE + 4, 32'hD);
    wr(BASE + 4, 32'h0, 0);
    rd_check("ovf_clear_zero_keeps", BASE + 4, 32'hD);
    wr(BASE + 4, 32'h8, 0);
    rd_check("ovf_clear", BASE + 4, 32'h5);
    wait_frames("ovf_frames_done", base + 5, 6 * FRM);
    check("ovf_frame_count", starts.size(), 32'd5);
    for (int i = 1; i < starts.size(); i++)
      check("frame_contiguous", starts[i] - starts[i-1], FRM);
    @(posedge clk);
    #1;
    rd_check("ovf_drained_status", BASE + 4, 32'h2);

    // Decode: out-of-window stores ignored, reads outside STATUS return 0
    base = frames_done;
    wr(BASE + 8, 32'hAA, 0);
    wr(32'h0000_0040, 32'hBB, 0);
    rd_check("decode_status", BASE + 4, 32'h2);
    repeat (20) @(posedge clk);
    #1;
    check("decode_no_frame", frames_done, base);
    check("decode_tx_idle", {31'b0, tx}, 32'd1);
    rd_check("rd_miss", 32'h0000_0040, 32'h0);
    rd_check("rd_txdata", BASE, 32'h0);
    rd_check("rd_base8", BASE + 8, 32'h0);
    rd_check("rd_status_alias", BASE + 6, 32'h2);
    wr(BASE + 1, 32'h1234_56A5, 1);
    wr(BASE + 3, 32'h0000_003C, 1);
    wait_frames("alias_frames_done", base + 2, 3 * FRM);
    @(posedge clk);
    #1;

    // Mid-frame reset during DATA bit 3 with two bytes queued
    base = frames_done;
    starts.delete();
    wr(BASE, 32'h11, 0);
    wr(BASE, 32'h22, 0);
    wr(BASE, 32'h33, 0);
    rd_check("queued_status", BASE + 4, 32'h1);
    k = 0;
    while (starts.size() == 0 && k < 10) begin
      @(posedge clk);
      k++;
    end
    check("mid_start_seen", starts.size(), 32'd1);
    repeat (17) @(posedge clk);
    #3;
    bus.a = BASE + 4;
    reset = 1'b1;
    #1;
    check("async_reset_tx", {31'b0, tx}, 32'd1);
    check("async_reset_busy", {31'b0, busy}, 32'd0);
    check("async_reset_status", bus.rd, 32'h2);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
    rd_check("post_reset_status", BASE + 4, 32'h2);
    repeat (3 * FRM) @(posedge clk);
    #1;
    check("post_reset_no_frames", frames_done, base);
    check("post_reset_tx", {31'b0, tx}, 32'd1);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the processor data bus, in parallel with `dmem`: it consumes the same `memwrite`/`dataadr`/`writedata` signals the MIPS core drives to data memory. Stores to the TXDATA register push bytes into a small FIFO. A serializer FSM shifts each byte out as an 8N1 frame on `tx`. A STATUS register lets software poll for space and detect dropped bytes; the top-level read mux selects `rd` from this block when the address is in its window.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit; must be ≥2.
- `FIFO_DEPTH`, default 4: byte entries; power of two.
- `BASE_ADDR`, default 32'hFFFF_FF00: register window base; 8-byte aligned.
- `clk` in 1: the single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `we` in 1: store strobe (core `memwrite`).
- `a` in 32: byte address (core `aluout`/`dataadr`).
- `wd` in 32: store data (core `writedata`).
- `rd` out 32: read data; combinational from `a`.
- `tx` out 1: serial line; idles high.
- `busy` out 1: 1 when the serializer is not in IDLE.

## Operation
- Decode: window hit when a[31:3] == BASE_ADDR[31:3]. a[2]=0 selects TXDATA; a[2]=1 selects STATUS. a[1:0] are ignored.
- TXDATA write (`we` and hit and a[2]=0):
  - If the registered count < FIFO_DEPTH, push wd[7:0].
  - Otherwise drop the byte and set the sticky `overflow` bit.
  - "Full" is judged on the pre-edge count. A push to a full FIFO in the same cycle as a pop is still dropped.
- STATUS read:
  - Bits: {28'b0, overflow, full, empty, busy}, i.e. bit0 busy, bit1 empty, bit2 full, bit3 overflow.
  - A TXDATA read returns 0. A miss returns 0.
- STATUS write with wd[3]=1 clears `overflow`; all other bits are ignored. A clear and a new overflow in the same cycle: the set wins.
- Serializer FSM:
  - IDLE: `tx`=1. If FIFO is non-empty, pop the head into the shift register and go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles. A 3-bit bit index is kept. After bit 7, go to STOP.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At the end, if FIFO is non-empty, pop and go straight to START with no idle cycle; otherwise go to IDLE.
- Baud counter: width clog2(CLKS_PER_BIT). It counts 0..CLKS_PER_BIT-1, then wraps to 0, and restarts at 0 on every state entry.
- FIFO pointers wrap modulo FIFO_DEPTH. The count is clog2(FIFO_DEPTH)+1 bits wide.
- `tx` is driven from a flop, so the line is glitch-free.

## Timing
- Reset values:
  - `tx`=1, `busy`=0, FSM=IDLE, FIFO empty (count 0, pointers 0), `overflow`=0.
  - STATUS reads 32'h0000_0002.
- A push at edge N makes the entry visible after N.
  - If idle, the FSM pops at edge N+1.
  - `tx` falls and `busy` rises after edge N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames are contiguous.
- `rd` is combinational with zero latency. It reflects state as of the last edge.
- Reset asserted mid-frame:
  - `tx` goes high and FIFO contents are discarded immediately, without waiting for a clock.
  - No partial frame resumes after reset.

## Structure
- Shared package `mmio_pkg` holds:
  - Constants: UART_BASE, TXDATA_OFS=0, STATUS_OFS=4.
  - Status bit indices: ST_BUSY=0, ST_EMPTY=1, ST_FULL=2, ST_OVF=3.
  - FSM state typedef: IDLE, START, DATA, STOP.
- Sub-module `sync_fifo`: parameterized width/depth, push/pop/full/empty/count, async active-high reset. `uart_tx_mmio` wraps it with the decode logic and the serializer.

## Test plan
All scenarios use CLKS_PER_BIT=4 and FIFO_DEPTH=4.
- **Reset state:** after reset, read STATUS → 32'h2, `tx`=1, `busy`=0.
- **Single frame:** write 0x55 to BASE+0 → one cycle later `tx` follows 0,1,0,1,0,1,0,1,0,1, each held 4 cycles (40 cycles total). Then `busy`=0 and STATUS=32'h2.
- **Overflow:** six TXDATA writes on consecutive cycles (0x01..0x06) → the first is popped immediately, 0x02–0x05 fill the FIFO, and 0x06 is dropped. STATUS=32'hD (overflow|full|busy). The line carries 5 contiguous frames, 200 cycles, with no idle gap.
- **Overflow clear:** write 32'h8 to BASE+4 → bit3 clears and the other bits are unchanged. Writing 32'h0 to BASE+4 leaves `overflow` set.
- **Decode:** a write to BASE+8 or to 32'h0000_0040 with `we`=1 → FIFO unchanged and `tx` stays high; a read of a non-window address gives `rd`=0. Writes to BASE+1..3 alias TXDATA.
- **Mid-frame reset:** assert `reset` asynchronously during DATA bit 3 with 2 bytes queued → `tx`=1 immediately. After release, STATUS=32'h2 and no further frames appear.
